// File: rtl/mmv_pkg.sv
// Shared types and helpers for the MemoryMapped request buffer.
// Request kinds travel with each buffered request so reads and writes keep their order.
package mmv_pkg;

  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } mmv_req_t;

  function automatic int mmv_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mmv_skid_stage.sv
// Generic 2-entry skid buffer: a main register feeding the output plus a skid register.
// in_busy comes straight from the skid valid flop, so upstream never sees a combinational busy path.
module mmv_skid_stage #(
  parameter int PWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [PWIDTH-1:0] in_payload,
  output logic              in_busy,
  output logic              out_valid,
  output logic [PWIDTH-1:0] out_payload,
  input  logic              out_ready
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [PWIDTH-1:0] main_data_q, main_data_d;
  logic [PWIDTH-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              advance;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid & ~skid_valid_q;
    advance      = main_valid_q & out_ready;

    // A full skid always refills main first; upstream is held off while it is full.
    if (advance) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d = in_payload;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_payload;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_payload;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_busy     = skid_valid_q;
  assign out_valid   = main_valid_q;
  assign out_payload = main_data_q;

endmodule

// File: rtl/mmv_req_buffer.sv
// Registered pipeline stage between a MemoryMapped master and slave: skid-buffered
// request path, registered read response, and a cap on outstanding downstream reads.
module mmv_req_buffer
  import mmv_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 32,
  parameter int RDPENDING = 4,
  parameter int CWIDTH    = mmv_cnt_width(RDPENDING)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] s_addr,
  input  logic              s_wreq,
  input  logic [DWIDTH-1:0] s_wdat,
  input  logic              s_rreq,
  output logic [DWIDTH-1:0] s_rdat,
  output logic              s_rval,
  output logic              s_busy,
  output logic [AWIDTH-1:0] m_addr,
  output logic              m_wreq,
  output logic [DWIDTH-1:0] m_wdat,
  output logic              m_rreq,
  input  logic [DWIDTH-1:0] m_rdat,
  input  logic              m_rval,
  input  logic              m_busy,
  output logic [CWIDTH-1:0] rd_pending
);

  localparam int                PWIDTH = 1 + AWIDTH + DWIDTH;
  localparam logic [CWIDTH-1:0] RD_MAX = CWIDTH'(RDPENDING);

  mmv_req_t          in_type;
  mmv_req_t          out_type;
  logic              in_valid;
  logic              in_busy;
  logic              out_valid;
  logic              out_ready;
  logic [PWIDTH-1:0] in_payload;
  logic [PWIDTH-1:0] out_payload;
  logic              rd_room;
  logic              rd_issue;
  logic [CWIDTH-1:0] rd_pending_q, rd_pending_d;
  logic              s_rval_q, s_rval_d;
  logic [DWIDTH-1:0] s_rdat_q, s_rdat_d;

  // A simultaneous write and read is illegal; the write wins and the read is dropped.
  always_comb begin
    in_type    = s_wreq ? REQ_WR : REQ_RD;
    in_valid   = s_wreq | s_rreq;
    in_payload = {in_type, s_addr, s_wdat};
  end

  mmv_skid_stage #(
    .PWIDTH(PWIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_payload (in_payload),
    .in_busy    (in_busy),
    .out_valid  (out_valid),
    .out_payload(out_payload),
    .out_ready  (out_ready)
  );

  // A read at the limit blocks the head of the queue, so later writes wait behind it.
  always_comb begin
    out_type  = mmv_req_t'(out_payload[PWIDTH-1]);
    rd_room   = rd_pending_q < RD_MAX;
    m_addr    = out_payload[PWIDTH-2 -: AWIDTH];
    m_wdat    = out_payload[DWIDTH-1:0];
    m_wreq    = out_valid & (out_type == REQ_WR);
    m_rreq    = out_valid & (out_type == REQ_RD) & rd_room;
    out_ready = ~m_busy & ((out_type == REQ_WR) | rd_room);
    rd_issue  = m_rreq & ~m_busy;
  end

  always_comb begin
    rd_pending_d = rd_pending_q;
    if (rd_issue && !m_rval) begin
      rd_pending_d = rd_pending_q + 1'b1;
    end else if (!rd_issue && m_rval && rd_pending_q != '0) begin
      rd_pending_d = rd_pending_q - 1'b1;
    end
    s_rval_d = m_rval;
    s_rdat_d = m_rval ? m_rdat : s_rdat_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pending_q <= '0;
      s_rval_q     <= 1'b0;
      s_rdat_q     <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      s_rval_q     <= s_rval_d;
      s_rdat_q     <= s_rdat_d;
    end
  end

  assign s_busy     = in_busy;
  assign s_rval     = s_rval_q;
  assign s_rdat     = s_rdat_q;
  assign rd_pending = rd_pending_q;

endmodule

// File: tb/tb_mmv_req_buffer.sv
// Directed, table-driven bench for mmv_req_buffer with RDPENDING=4, plus a hand-written
// asynchronous-reset sequence.
module tb_mmv_req_buffer;

  localparam int DWIDTH    = 8;
  localparam int AWIDTH    = 32;
  localparam int RDPENDING = 4;
  localparam int CWIDTH    = $clog2(RDPENDING + 1);
  localparam int NVEC      = 36;

  logic              clk;
  logic              reset;
  logic [AWIDTH-1:0] s_addr;
  logic              s_wreq;
  logic [DWIDTH-1:0] s_wdat;
  logic              s_rreq;
  logic [DWIDTH-1:0] s_rdat;
  logic              s_rval;
  logic              s_busy;
  logic [AWIDTH-1:0] m_addr;
  logic              m_wreq;
  logic [DWIDTH-1:0] m_wdat;
  logic              m_rreq;
  logic [DWIDTH-1:0] m_rdat;
  logic              m_rval;
  logic              m_busy;
  logic [CWIDTH-1:0] rd_pending;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic              wreq;
    logic              rreq;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdat;
    logic              mbusy;
    logic              mrval;
    logic [DWIDTH-1:0] mrdat;
    logic              e_sbusy;
    logic              e_mwreq;
    logic              e_mrreq;
    logic              chk_addr;
    logic [AWIDTH-1:0] e_addr;
    logic [DWIDTH-1:0] e_wdat;
    logic              e_srval;
    logic [DWIDTH-1:0] e_srdat;
    logic [CWIDTH-1:0] e_rd;
  } vec_t;

  vec_t vecs[NVEC];

  mmv_req_buffer #(
    .DWIDTH   (DWIDTH),
    .AWIDTH   (AWIDTH),
    .RDPENDING(RDPENDING)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_addr    (s_addr),
    .s_wreq    (s_wreq),
    .s_wdat    (s_wdat),
    .s_rreq    (s_rreq),
    .s_rdat    (s_rdat),
    .s_rval    (s_rval),
    .s_busy    (s_busy),
    .m_addr    (m_addr),
    .m_wreq    (m_wreq),
    .m_wdat    (m_wdat),
    .m_rreq    (m_rreq),
    .m_rdat    (m_rdat),
    .m_rval    (m_rval),
    .m_busy    (m_busy),
    .rd_pending(rd_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wreq, input logic rreq, input logic [AWIDTH-1:0] addr,
                                input logic [DWIDTH-1:0] wdat, input logic mbusy,
                                input logic mrval, input logic [DWIDTH-1:0] mrdat);
    @(negedge clk);
    s_wreq = wreq;
    s_rreq = rreq;
    s_addr = addr;
    s_wdat = wdat;
    m_busy = mbusy;
    m_rval = mrval;
    m_rdat = mrdat;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " s_busy"}, 32'(s_busy), 32'd0);
    check_output({tag, " s_rval"}, 32'(s_rval), 32'd0);
    check_output({tag, " s_rdat"}, 32'(s_rdat), 32'd0);
    check_output({tag, " m_wreq"}, 32'(m_wreq), 32'd0);
    check_output({tag, " m_rreq"}, 32'(m_rreq), 32'd0);
    check_output({tag, " m_addr"}, 32'(m_addr), 32'd0);
    check_output({tag, " m_wdat"}, 32'(m_wdat), 32'd0);
    check_output({tag, " rd_pending"}, 32'(rd_pending), 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // wreq rreq addr wdat mbusy mrval mrdat | sbusy mwreq mrreq chk addr wdat srval srdat rd
    vecs[0]  = '{1, 0, 32'h10, 8'hA5, 0, 0, 8'hEE, 0, 1, 0, 1, 32'h10, 8'hA5, 0, 8'h00, 0};
    vecs[1]  = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h00, 0};
    vecs[2]  = '{0, 1, 32'h20, 8'h00, 0, 0, 8'hEE, 0, 0, 1, 1, 32'h20, 8'h00, 0, 8'h00, 0};
    vecs[3]  = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h00, 1};
    vecs[4]  = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h00, 1};
    vecs[5]  = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h3C, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h3C, 0};
    vecs[6]  = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h3C, 0};
    vecs[7]  = '{1, 0, 32'h01, 8'h11, 1, 0, 8'hEE, 0, 1, 0, 1, 32'h01, 8'h11, 0, 8'h3C, 0};
    vecs[8]  = '{1, 0, 32'h02, 8'h22, 1, 0, 8'hEE, 1, 1, 0, 1, 32'h01, 8'h11, 0, 8'h3C, 0};
    vecs[9]  = '{1, 0, 32'h03, 8'h33, 1, 0, 8'hEE, 1, 1, 0, 1, 32'h01, 8'h11, 0, 8'h3C, 0};
    vecs[10] = '{1, 0, 32'h03, 8'h33, 1, 0, 8'hEE, 1, 1, 0, 1, 32'h01, 8'h11, 0, 8'h3C, 0};
    vecs[11] = '{1, 0, 32'h03, 8'h33, 1, 0, 8'hEE, 1, 1, 0, 1, 32'h01, 8'h11, 0, 8'h3C, 0};
    vecs[12] = '{1, 0, 32'h03, 8'h33, 0, 0, 8'hEE, 0, 1, 0, 1, 32'h02, 8'h22, 0, 8'h3C, 0};
    vecs[13] = '{1, 0, 32'h03, 8'h33, 0, 0, 8'hEE, 0, 1, 0, 1, 32'h03, 8'h33, 0, 8'h3C, 0};
    vecs[14] = '{1, 0, 32'h04, 8'h44, 0, 0, 8'hEE, 0, 1, 0, 1, 32'h04, 8'h44, 0, 8'h3C, 0};
    vecs[15] = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h3C, 0};
    vecs[16] = '{0, 1, 32'h40, 8'h00, 0, 0, 8'hEE, 0, 0, 1, 1, 32'h40, 8'h00, 0, 8'h3C, 0};
    vecs[17] = '{0, 1, 32'h41, 8'h00, 0, 0, 8'hEE, 0, 0, 1, 1, 32'h41, 8'h00, 0, 8'h3C, 1};
    vecs[18] = '{0, 1, 32'h42, 8'h00, 0, 0, 8'hEE, 0, 0, 1, 1, 32'h42, 8'h00, 0, 8'h3C, 2};
    vecs[19] = '{0, 1, 32'h43, 8'h00, 0, 0, 8'hEE, 0, 0, 1, 1, 32'h43, 8'h00, 0, 8'h3C, 3};
    vecs[20] = '{0, 1, 32'h44, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 1, 32'h44, 8'h00, 0, 8'h3C, 4};
    vecs[21] = '{0, 1, 32'h45, 8'h00, 0, 0, 8'hEE, 1, 0, 0, 1, 32'h44, 8'h00, 0, 8'h3C, 4};
    vecs[22] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h91, 1, 0, 1, 1, 32'h44, 8'h00, 1, 8'h91, 3};
    vecs[23] = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 1, 32'h45, 8'h00, 0, 8'h91, 4};
    vecs[24] = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 1, 32'h45, 8'h00, 0, 8'h91, 4};
    vecs[25] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h92, 0, 0, 1, 1, 32'h45, 8'h00, 1, 8'h92, 3};
    vecs[26] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h93, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h93, 3};
    vecs[27] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h94, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h94, 2};
    vecs[28] = '{0, 1, 32'h50, 8'h00, 0, 0, 8'hEE, 0, 0, 1, 1, 32'h50, 8'h00, 0, 8'h94, 2};
    vecs[29] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h95, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h95, 2};
    vecs[30] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h96, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h96, 1};
    vecs[31] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h97, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h97, 0};
    vecs[32] = '{0, 0, 32'h00, 8'h00, 0, 1, 8'h77, 0, 0, 0, 0, 32'h00, 8'h00, 1, 8'h77, 0};
    vecs[33] = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h77, 0};
    vecs[34] = '{1, 1, 32'h60, 8'h5A, 0, 0, 8'hEE, 0, 1, 0, 1, 32'h60, 8'h5A, 0, 8'h77, 0};
    vecs[35] = '{0, 0, 32'h00, 8'h00, 0, 0, 8'hEE, 0, 0, 0, 0, 32'h00, 8'h00, 0, 8'h77, 0};

    reset  = 1'b1;
    s_wreq = 1'b0;
    s_rreq = 1'b0;
    s_addr = '0;
    s_wdat = '0;
    m_busy = 1'b0;
    m_rval = 1'b0;
    m_rdat = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].wreq, vecs[i].rreq, vecs[i].addr, vecs[i].wdat,
                     vecs[i].mbusy, vecs[i].mrval, vecs[i].mrdat);
      check_output($sformatf("row%0d s_busy", i), 32'(s_busy), 32'(vecs[i].e_sbusy));
      check_output($sformatf("row%0d m_wreq", i), 32'(m_wreq), 32'(vecs[i].e_mwreq));
      check_output($sformatf("row%0d m_rreq", i), 32'(m_rreq), 32'(vecs[i].e_mrreq));
      check_output($sformatf("row%0d rd_pending", i), 32'(rd_pending), 32'(vecs[i].e_rd));
      check_output($sformatf("row%0d s_rval", i), 32'(s_rval), 32'(vecs[i].e_srval));
      check_output($sformatf("row%0d s_rdat", i), 32'(s_rdat), 32'(vecs[i].e_srdat));
      if (vecs[i].chk_addr)
        check_output($sformatf("row%0d m_addr", i), m_addr, vecs[i].e_addr);
      if (vecs[i].chk_addr && vecs[i].e_mwreq)
        check_output($sformatf("row%0d m_wdat", i), 32'(m_wdat), 32'(vecs[i].e_wdat));
    end

    // Fill main and skid with three reads outstanding, then reset between edges.
    apply_stimulus(0, 1, 32'h70, 8'h00, 0, 0, 8'h00);
    apply_stimulus(0, 1, 32'h71, 8'h00, 0, 0, 8'h00);
    apply_stimulus(0, 1, 32'h72, 8'h00, 0, 0, 8'h00);
    apply_stimulus(1, 0, 32'h80, 8'h12, 0, 0, 8'h00);
    apply_stimulus(1, 0, 32'h81, 8'h13, 1, 0, 8'h00);
    check_output("prereset rd_pending", 32'(rd_pending), 32'd3);
    check_output("prereset s_busy", 32'(s_busy), 32'd1);
    check_output("prereset m_wreq", 32'(m_wreq), 32'd1);
    check_output("prereset m_addr", m_addr, 32'h80);
    check_output("prereset s_rdat", 32'(s_rdat), 32'h77);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");

    @(negedge clk);
    s_wreq = 1'b0;
    s_rreq = 1'b0;
    m_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(0, 0, 32'h00, 8'h00, 0, 0, 8'h00);
    check_all_zero("post_reset idle");
    apply_stimulus(1, 0, 32'h90, 8'h33, 0, 0, 8'h00);
    check_output("post_reset m_wreq", 32'(m_wreq), 32'd1);
    check_output("post_reset m_rreq", 32'(m_rreq), 32'd0);
    check_output("post_reset m_addr", m_addr, 32'h90);
    check_output("post_reset m_wdat", 32'(m_wdat), 32'h33);
    apply_stimulus(0, 0, 32'h00, 8'h00, 0, 0, 8'h00);
    check_output("post_reset drain m_wreq", 32'(m_wreq), 32'd0);
    check_output("post_reset drain s_busy", 32'(s_busy), 32'd0);
    check_output("post_reset drain rd_pending", 32'(rd_pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
